// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: access kinds, fault codes, FSM states and
// the pipeline Signals bundle passed between ALU, memory and writeback.
package mem_stage_pkg;

  // Stores only use the first three encodings to select access size.
  typedef enum logic [2:0] {
    LoadByte, LoadHalf, LoadWord, LoadByteU, LoadHalfU
  } MemType;

  typedef enum logic [1:0] {None, Misaligned, Illegal, Timeout} MemFault;

  typedef enum logic {IDLE, BUSY} MemState;

  // Never encodes as zero so an all-zero Signals word is a clean reset value.
  typedef enum logic [2:0] {Never, Always, Eq, Ne, Lt, Ge, Ltu, Geu} CondType;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] wdata;
    logic [31:0] reg2;
    logic [4:0]  rd;
    logic        wback;
    logic        memr;
    logic        memw;
    MemType      memt;
    CondType     cond;
    logic        branch;
    logic [3:0]  flags;
  } Signals;

  function automatic logic misaligned(input MemType t, input logic [1:0] a);
    case (t)
      LoadByte, LoadByteU: return 1'b0;
      LoadHalf, LoadHalfU: return a[0];
      default:             return a != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the memory (slave).
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_load_extend.sv
// Selects the addressed byte/half lane of a load word and sign- or zero-extends it.
module load_extend
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  MemType      memt,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{addr, 3'b000} +: 8];
    half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
    case (memt)
      LoadByte:  result = {{24{byte_lane[7]}}, byte_lane};
      LoadByteU: result = {24'h0, byte_lane};
      LoadHalf:  result = {{16{half_lane[15]}}, half_lane};
      LoadHalfU: result = {16'h0, half_lane};
      default:   result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: passes ALU results through in one cycle and runs one
// blocking data-memory transaction at a time, stalling upstream while busy.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  Signals             i_signals,
  output Signals             o_signals,
  output logic               stall,
  mem_stage_if.master        dmem,
  output MemFault            fault
);

  localparam int unsigned CNT_BITS = $clog2(MAX_WAIT + 1);
  localparam int unsigned WAIT_W   = (CNT_BITS > 8) ? CNT_BITS : 8;

  MemState           state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  Signals            hold_q, hold_d;
  Signals            o_q, o_d;
  MemFault           fault_q, fault_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              we_q, we_d;
  logic [31:0]       ld_data;
  logic [1:0]        off;

  load_extend u_load_extend (
    .rdata  (dmem.dmem_rdata),
    .addr   (hold_q.wdata[1:0]),
    .memt   (hold_q.memt),
    .result (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    hold_d      = hold_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    we_d        = we_q;
    o_d         = o_q;
    o_d.valid   = 1'b0;
    fault_d     = None;
    off         = i_signals.wdata[1:0];

    unique case (state_q)
      IDLE: begin
        if (i_signals.valid) begin
          if (i_signals.memr && i_signals.memw) begin
            fault_d = Illegal;
          end else if (!i_signals.memr && !i_signals.memw) begin
            o_d = i_signals;
          end else if (misaligned(i_signals.memt, off)) begin
            fault_d = Misaligned;
          end else begin
            state_d = BUSY;
            wait_d  = '0;
            hold_d  = i_signals;
            addr_d  = {i_signals.wdata[31:2], 2'b00};
            we_d    = i_signals.memw;
            case (i_signals.memt)
              LoadByte, LoadByteU: begin
                be_d    = 4'b0001 << off;
                wdata_d = {4{i_signals.reg2[7:0]}};
              end
              LoadHalf, LoadHalfU: begin
                be_d    = 4'b0011 << off;
                wdata_d = {2{i_signals.reg2[15:0]}};
              end
              default: begin
                be_d    = 4'hF;
                wdata_d = i_signals.reg2;
              end
            endcase
          end
        end
      end
      BUSY: begin
        // Ready takes priority over the timeout on the same cycle.
        if (dmem.dmem_ready) begin
          state_d = IDLE;
          o_d     = hold_q;
          if (!hold_q.memw) o_d.wdata = ld_data;
        end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
          state_d = IDLE;
          fault_d = Timeout;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
      hold_q  <= '0;
      o_q     <= '0;
      fault_q <= None;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      hold_q  <= hold_d;
      o_q     <= o_d;
      fault_q <= fault_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
    end
  end

  assign dmem.dmem_req   = (state_q == BUSY);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;
  assign stall           = (state_q == BUSY);
  assign o_signals       = o_q;
  assign fault           = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected results, a memory
// responder plays the bus side, and a monitor checks outputs as they appear.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int unsigned MAXW = 4;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  Signals  i_signals;
  Signals  o_signals;
  logic    stall;
  MemFault fault;

  mem_stage_if bus ();

  mem_stage #(.MAX_WAIT(MAXW)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_signals (i_signals),
    .o_signals (o_signals),
    .stall     (stall),
    .dmem      (bus),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cycle  = 0;

  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    bit      is_fault;
    MemFault f;
    Signals  s;
    int      at;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    bit          chk_lanes;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          d;
    logic [31:0] rdata;
    int          req_cycles;
  } bus_t;

  exp_t sb_q[$];
  bus_t bus_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int size_of(input MemType t);
    if (t == LoadByte || t == LoadByteU) return 1;
    if (t == LoadHalf || t == LoadHalfU) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input int off, input MemType t);
    longint v;
    int     sz;
    sz = size_of(t);
    if (sz == 4) return rdata;
    v = longint'(rdata >> (8 * off)) & ((longint'(1) << (8 * sz)) - 1);
    if ((t == LoadByte || t == LoadHalf) && v >= (longint'(1) << (8 * sz - 1)))
      v = v - (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  function automatic Signals mk(input bit v, input bit r, input bit w, input MemType t,
                                input logic [31:0] addr, input logic [31:0] reg2);
    Signals s;
    s.valid  = v;
    s.pc     = $urandom;
    s.wdata  = addr;
    s.reg2   = reg2;
    s.rd     = 5'($urandom);
    s.wback  = 1'($urandom);
    s.memr   = r;
    s.memw   = w;
    s.memt   = t;
    s.cond   = CondType'($urandom_range(0, 7));
    s.branch = 1'($urandom);
    s.flags  = 4'($urandom);
    return s;
  endfunction

  // Presents one instruction once upstream may advance, and records what the
  // bus and the output side must show for it.
  task automatic issue(input Signals s, input int d, input logic [31:0] rdata, input bit expect_out);
    int   g;
    int   sz;
    int   off;
    int   c;
    exp_t e;
    bus_t b;
    g = 0;
    while (stall !== 1'b0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) check("stall_release", 128'(stall), 128'(0));
    i_signals = s;
    c   = cycle;
    sz  = size_of(s.memt);
    off = int'(s.wdata % 4);
    e.s = s;
    e.f = None;
    e.is_fault = 1'b0;
    if (s.valid) begin
      if (s.memr && s.memw) begin
        e.is_fault = 1'b1; e.f = Illegal; e.at = c + 1; sb_q.push_back(e);
      end else if (!s.memr && !s.memw) begin
        e.at = c + 1; sb_q.push_back(e);
      end else if (off % sz != 0) begin
        e.is_fault = 1'b1; e.f = Misaligned; e.at = c + 1; sb_q.push_back(e);
      end else begin
        b.addr = s.wdata - 32'(off);
        b.we = s.memw;
        b.chk_lanes = s.memw;
        b.be = '0;
        b.wdata = '0;
        for (int i = 0; i < 4; i++) begin
          if (i >= off && i < off + sz) b.be[i] = 1'b1;
          b.wdata[8*i +: 8] = s.reg2[8*(i % sz) +: 8];
        end
        b.d = d;
        b.rdata = rdata;
        b.req_cycles = (d < int'(MAXW)) ? d + 1 : int'(MAXW);
        bus_q.push_back(b);
        if (expect_out) begin
          if (d >= int'(MAXW)) begin
            e.is_fault = 1'b1; e.f = Timeout; e.at = c + 1 + int'(MAXW);
          end else begin
            if (s.memr) e.s.wdata = model_load(rdata, off, s.memt);
            e.at = c + d + 2;
          end
          sb_q.push_back(e);
        end
      end
    end
    @(negedge clk);
  endtask

  // Output monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && (o_signals.valid === 1'b1 || fault !== None)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 128'({o_signals.valid, fault}), 128'(0));
      end else begin
        e = sb_q.pop_front();
        check("output_cycle", 128'(cycle), 128'(e.at));
        if (e.is_fault) begin
          check("fault", 128'(fault), 128'(e.f));
          check("valid_with_fault", 128'(o_signals.valid), 128'(0));
        end else begin
          check("o_signals", 128'(o_signals), 128'(e.s));
          check("fault_with_output", 128'(fault), 128'(None));
        end
      end
    end
  end

  // Memory responder
  int   rcnt = 0;
  int   scnt = 0;
  bit   have = 1'b0;
  bus_t cur;

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      rcnt = 0; scnt = 0; have = 1'b0;
      bus.dmem_ready = 1'b0;
      bus.dmem_rdata = '0;
    end else begin
      if (stall === 1'b1) scnt++;
      if (bus.dmem_req === 1'b1) begin
        if (!have) begin
          if (bus_q.size() == 0) begin
            check("unexpected_req", 128'(bus.dmem_req), 128'(0));
            cur = '{addr: bus.dmem_addr, we: bus.dmem_we, chk_lanes: 1'b0, be: '0,
                    wdata: '0, d: 0, rdata: '0, req_cycles: 1};
          end else begin
            cur = bus_q.pop_front();
          end
          have = 1'b1;
        end
        rcnt++;
        check("dmem_addr", 128'(bus.dmem_addr), 128'(cur.addr));
        check("dmem_we", 128'(bus.dmem_we), 128'(cur.we));
        if (cur.chk_lanes) begin
          check("dmem_be", 128'(bus.dmem_be), 128'(cur.be));
          check("dmem_wdata", 128'(bus.dmem_wdata), 128'(cur.wdata));
        end
        if (rcnt == cur.d + 1) begin
          bus.dmem_ready = 1'b1;
          bus.dmem_rdata = cur.rdata;
        end else begin
          bus.dmem_ready = 1'b0;
          bus.dmem_rdata = $urandom;
        end
      end else begin
        if (have) begin
          check("req_cycles", 128'(rcnt), 128'(cur.req_cycles));
          check("stall_cycles", 128'(scnt), 128'(cur.req_cycles));
          have = 1'b0;
          rcnt = 0;
          scnt = 0;
        end
        bus.dmem_ready = ($urandom_range(0, 3) == 0);
        bus.dmem_rdata = $urandom;
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    Signals s;
    int     k;
    int     g;
    i_signals = '0;
    #1 rst = 1'b0;
    #1;
    check("rst_o_valid", 128'(o_signals.valid), 128'(0));
    check("rst_o_wback", 128'(o_signals.wback), 128'(0));
    check("rst_o_memr", 128'(o_signals.memr), 128'(0));
    check("rst_o_memw", 128'(o_signals.memw), 128'(0));
    check("rst_o_cond", 128'(o_signals.cond), 128'(Never));
    check("rst_fault", 128'(fault), 128'(None));
    check("rst_stall", 128'(stall), 128'(0));
    check("rst_dmem_req", 128'(bus.dmem_req), 128'(0));
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // First accept right after reset release, then directed cases.
    issue(mk(1, 0, 0, LoadWord, 32'h1234_5678, 32'h9), 0, 0, 1);
    issue(mk(1, 1, 0, LoadByte, 32'h0000_1003, 32'h0), 2, 32'h80FF_FF00, 1);
    issue(mk(1, 0, 1, LoadHalf, 32'h0000_2002, 32'h0000_ABCD), 0, 0, 1);
    issue(mk(1, 1, 0, LoadWord, 32'h0000_3001, 32'h0), 0, 0, 1);
    issue(mk(1, 1, 0, LoadWord, 32'h0000_4000, 32'h0), 1000, 0, 1);
    issue(mk(1, 1, 0, LoadWord, 32'h0000_4100, 32'h0), int'(MAXW) - 1, 32'hCAFE_F00D, 1);
    issue(mk(1, 1, 1, LoadWord, 32'h0000_4200, 32'h0), 0, 0, 1);
    issue(mk(0, 1, 0, LoadWord, 32'h0000_4300, 32'h0), 0, 0, 1);
    issue(mk(1, 0, 0, LoadWord, 32'h0000_0077, 32'h5), 0, 0, 1);
    issue(mk(1, 1, 0, LoadHalfU, 32'h0000_0010, 32'h0), 0, 32'h0000_8001, 1);

    // Reset while a load is outstanding abandons it.
    issue(mk(1, 1, 0, LoadWord, 32'h0000_5000, 32'h0), 1000, 0, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_busy_rst_req", 128'(bus.dmem_req), 128'(0));
    check("mid_busy_rst_stall", 128'(stall), 128'(0));
    @(negedge clk);
    check("mid_busy_rst_valid", 128'(o_signals.valid), 128'(0));
    check("mid_busy_rst_fault", 128'(fault), 128'(None));
    @(negedge clk);
    rst = 1'b1;
    issue(mk(1, 0, 0, LoadWord, 32'h0000_6000, 32'h1), 0, 0, 1);

    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0:       s = mk(0, 1'($urandom), 1'($urandom), MemType'($urandom_range(0, 4)), $urandom, $urandom);
        1, 2:    s = mk(1, 0, 0, MemType'($urandom_range(0, 4)), $urandom, $urandom);
        3, 4, 5: s = mk(1, 1, 0, MemType'($urandom_range(0, 4)), $urandom, $urandom);
        6, 7, 8: s = mk(1, 0, 1, MemType'($urandom_range(0, 2)), $urandom, $urandom);
        default: s = mk(1, 1, 1, MemType'($urandom_range(0, 4)), $urandom, $urandom);
      endcase
      issue(s, $urandom_range(0, 5), $urandom, 1);
    end

    i_signals = '0;
    g = 0;
    while ((sb_q.size() != 0 || have) && g < 50) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 128'(sb_q.size()), 128'(0));
    check("bus_queue_drained", 128'(bus_q.size()), 128'(0));
    check("idle_stall_count", 128'(scnt), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: MAX_WAIT, default 255, max cycles in BUSY without dmem_ready before abort.
REQ-002 Port: clk  input  1  single clock, all state on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: i_signals  input  Signals  ALU-stage output; wdata = effective address, reg2 = store data.
REQ-005 Port: o_signals  output  Signals  registered result toward writeback.
REQ-006 Port: stall  output  1  upstream must hold i_signals while high.
REQ-007 Port: dmem_req  output  1  bus request.
REQ-008 Port: dmem_we  output  1  1 = store, 0 = load.
REQ-009 Port: dmem_addr  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-010 Port: dmem_wdata  output  32  lane-replicated store data.
REQ-011 Port: dmem_be  output  4  byte enables.
REQ-012 Port: dmem_ready  input  1  bus completes the request this cycle.
REQ-013 Port: dmem_rdata  input  32  load data, valid when dmem_ready.
REQ-014 Port: fault  output  MemFault  one-cycle fault pulse; None otherwise.

Function
REQ-015 Valid non-memory op (memr=memw=0) in IDLE: registered to o_signals next edge, fields unchanged, latency 1.
REQ-016 i_signals.valid=0: no bus request; o_signals.valid=0 next edge.
REQ-017 FSM states IDLE, BUSY; IDLE->BUSY on accepted valid aligned memory op; BUSY->IDLE on dmem_ready or timeout.
REQ-018 On accept, address, we, be, wdata and the instruction's Signals are registered; bus outputs driven from those registers only, stable through BUSY.
REQ-019 dmem_req = (state==BUSY); stall = (state==BUSY); o_signals.valid=0 every cycle spent in BUSY.
REQ-020 BUSY with dmem_ready=1: next edge o_signals.valid=1, held Signals; loads set wdata = extended data; stores leave wdata unchanged; minimum memory-op latency 2 cycles.
REQ-021 Store be: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'hF; byte data replicated x4, half data x2.
REQ-022 Load extract: lane selected by addr[1:0]; LoadByte/LoadHalf sign-extend; LoadByteU/LoadHalfU zero-extend; LoadWord unchanged.
REQ-023 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no request, stay IDLE, fault=Misaligned next edge, o_signals.valid=0.
REQ-024 memr=memw=1: no request, fault=Illegal next edge, o_signals.valid=0.
REQ-025 Wait counter 8+ bits, clears on entering BUSY; at MAX_WAIT cycles without ready: dmem_req drops next edge, IDLE, fault=Timeout, o_signals.valid=0.
REQ-026 dmem_ready while IDLE is ignored; dmem_ready on the timeout cycle completes normally (ready wins).
REQ-027 o_signals.pc passes through unmodified; cond, branch, flags pass through with the held instruction.

Reset
REQ-028 rst low asynchronously forces: state IDLE, dmem_req 0, stall 0, fault None, wait counter 0, o_signals.valid 0, wback 0, memr 0, memw 0, cond Never.
REQ-029 Reset during BUSY abandons the transaction; no fault and no o_signals.valid after rst release.
REQ-030 First accept possible on the first rising edge after rst goes high.

Structure
REQ-031 Common package holds MemType (LoadByte, LoadHalf, LoadWord, LoadByteU, LoadHalfU; stores use the first three), MemFault (None, Misaligned, Illegal, Timeout), MemState (IDLE, BUSY).
REQ-032 One combinational sub-module load_extend (rdata, addr[1:0], memt -> 32-bit result); store lane/be logic stays in mem_stage.

Verification
REQ-033 Load LoadByte addr 0x1003, rdata 0x80FF_FF00, ready after 3 cycles -> stall 3 cycles, o_signals.wdata 0xFFFF_FF80 valid once.
REQ-034 Store half addr 0x2002, reg2 0x0000_ABCD -> dmem_addr 0x2000, be 4'b1100, wdata 0xABCD_ABCD, we=1.
REQ-035 LoadWord addr 0x3001 -> no dmem_req, fault=Misaligned one cycle, o_signals.valid 0.
REQ-036 MAX_WAIT=4, ready never -> dmem_req high exactly 4 cycles, fault=Timeout, stall drops.
REQ-037 rst low mid-BUSY -> dmem_req 0 immediately, no output after release; next ALU op passes with latency 1.
REQ-038 Back-to-back Add then LoadHalfU addr 0x10 rdata 0x0000_8001 with ready same cycle -> Add valid cycle 1, load valid cycle 3 wdata 0x0000_8001.
